// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU hold code, sequencer states and instruction field positions
// shared by the control unit and the ALU.
package cpu_pkg;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SHL  = 4'h2;
    localparam logic [3:0] OP_SHR  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_JN   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_HOLD = 4'hF;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    function automatic logic is_alu(input logic [3:0] op);
        return op <= OP_MOV;
    endfunction
endpackage

// File: rtl/branch_eval.sv
// branch_eval: decides whether a conditional jump is taken from the latched Z/C/N flags.
module branch_eval
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_z,
    input  logic       i_c,
    input  logic       i_n,
    output logic       o_take_branch
);
    assign o_take_branch = (i_opcode == OP_JZ && i_z) ||
                           (i_opcode == OP_JC && i_c) ||
                           (i_opcode == OP_JN && i_n);
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/WB sequencer issuing ALU ops,
// register-file writes and flag-based jumps.
module control_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         instr,
    input  logic                zero_flag,
    input  logic                carrier_flag,
    input  logic                negative_flag,
    output logic [PC_WIDTH-1:0] pc,
    output logic [3:0]          alu_op,
    output logic [1:0]          ra_addr,
    output logic [1:0]          rb_addr,
    output logic [1:0]          wb_addr,
    output logic                reg_we,
    output logic                wb_sel,
    output logic [7:0]          imm,
    output logic                halted
);
    state_t              r_state;
    logic [15:0]         r_ir;
    logic [PC_WIDTH-1:0] r_pc;
    logic [3:0]          r_alu_op;
    logic                r_z, r_c, r_n, r_reg_we, r_halted;
    logic [3:0]          w_op;
    logic [PC_WIDTH-1:0] w_pc_inc, w_target;
    logic                w_take;

    assign w_op     = r_ir[OPC_LSB +: 4];
    assign w_pc_inc = r_pc + PC_WIDTH'(1);
    assign w_target = PC_WIDTH'(r_ir[IMM_LSB +: 8]);

    branch_eval u_branch (
        .i_opcode      (w_op),
        .i_z           (r_z),
        .i_c           (r_c),
        .i_n           (r_n),
        .o_take_branch (w_take)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_alu_op <= ALU_HOLD;
            r_reg_we <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir    <= instr;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_alu(w_op)) begin
                        r_state  <= S_EXEC;
                        r_alu_op <= w_op;
                    end else if (w_op == OP_LDI) begin
                        r_state  <= S_WB;
                        r_reg_we <= 1'b1;
                    end else if (w_op == OP_HALT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                        r_pc    <= (w_op == OP_JMP || w_take) ? w_target : w_pc_inc;
                    end
                end
                S_EXEC: begin
                    r_state  <= S_WB;
                    r_alu_op <= ALU_HOLD;
                    r_reg_we <= 1'b1;
                end
                S_WB: begin
                    // ALU result and flags are stable here because alu_op is back to hold
                    if (is_alu(w_op)) begin
                        r_z <= zero_flag;
                        r_c <= carrier_flag;
                        r_n <= negative_flag;
                    end
                    r_pc     <= w_pc_inc;
                    r_reg_we <= 1'b0;
                    r_state  <= S_FETCH;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Gating with rst_n keeps a WB write from landing on the same edge as a reset.
    assign reg_we  = r_reg_we & rst_n;
    assign pc      = r_pc;
    assign alu_op  = r_alu_op;
    assign halted  = r_halted;
    assign ra_addr = r_ir[RD_LSB +: 2];
    assign rb_addr = r_ir[RS_LSB +: 2];
    assign wb_addr = r_ir[RD_LSB +: 2];
    assign wb_sel  = (w_op == OP_LDI);
    assign imm     = r_ir[IMM_LSB +: 8];
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: surrounds control_unit with instruction memory, register file and ALU,
// and compares each instruction against an ISA-level reference model.
module tb_control_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr;
    logic        zero_flag = 1'b0, carrier_flag = 1'b0, negative_flag = 1'b0;
    logic [7:0]  pc;
    logic [3:0]  alu_op;
    logic [1:0]  ra_addr, rb_addr, wb_addr;
    logic        reg_we, wb_sel, halted;
    logic [7:0]  imm;

    logic [15:0] imem [256];
    logic [7:0]  rf [4] = '{default: 8'h00};
    logic [7:0]  alu_res = 8'h00;
    logic [8:0]  alu_next;

    logic [7:0]  m_pc;
    logic [7:0]  m_rf [4] = '{default: 8'h00};
    logic        m_z, m_c, m_n;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    control_unit #(.PC_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .zero_flag     (zero_flag),
        .carrier_flag  (carrier_flag),
        .negative_flag (negative_flag),
        .pc            (pc),
        .alu_op        (alu_op),
        .ra_addr       (ra_addr),
        .rb_addr       (rb_addr),
        .wb_addr       (wb_addr),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .imm           (imm),
        .halted        (halted)
    );

    // {carry, result} of an 8-bit ALU operation
    function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0:    return {1'b0, a} + {1'b0, b};
            4'h1:    return {1'b0, a} - {1'b0, b};
            4'h2:    return {a, 1'b0};
            4'h3:    return {a[0], 1'b0, a[7:1]};
            default: return {1'b0, b};
        endcase
    endfunction

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                        input logic [7:0] im);
        return {op, rd, rs, im};
    endfunction

    assign instr    = imem[pc];
    assign alu_next = alu(alu_op, rf[ra_addr], rf[rb_addr]);

    always @(posedge clk) begin
        if (alu_op != ALU_HOLD) begin
            {carrier_flag, alu_res} <= alu_next;
            zero_flag     <= alu_next[7:0] == 8'h00;
            negative_flag <= alu_next[7];
        end
        if (reg_we) rf[wb_addr] <= wb_sel ? imm : alu_res;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_z  = 1'b0;
        m_c  = 1'b0;
        m_n  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Runs one non-HALT instruction from its FETCH cycle to the next FETCH cycle.
    task automatic step();
        logic [15:0] w;
        logic [3:0]  op, op_seen;
        logic [1:0]  rd, rs, wa_seen;
        logic [7:0]  im, npc, imm_seen;
        logic [8:0]  r;
        logic        sel_seen;
        int          cyc, we_n, ex_n, we_at, ex_at;
        w  = imem[m_pc];
        op = w[15:12];
        rd = w[11:10];
        rs = w[9:8];
        im = w[7:0];
        npc = m_pc + 8'd1;
        we_n = 0; ex_n = 0; we_at = -1; ex_at = -1;
        sel_seen = 1'b0; imm_seen = 8'h00; wa_seen = 2'd0; op_seen = ALU_HOLD;
        check("pc_fetch", 32'(pc), 32'(m_pc));
        if (op <= 4'h4) begin
            r = alu(op, m_rf[rd], m_rf[rs]);
            m_rf[rd] = r[7:0];
            m_c = r[8];
            m_z = r[7:0] == 8'h00;
            m_n = r[7];
            cyc = 4;
        end else if (op == 4'h5) begin
            m_rf[rd] = im;
            cyc = 3;
        end else begin
            cyc = 2;
            if (op == 4'h6 || (op == 4'h7 && m_z) || (op == 4'h8 && m_c) || (op == 4'h9 && m_n)) npc = im;
        end
        for (int k = 0; k < cyc; k++) begin
            if (reg_we) begin
                we_n++; we_at = k; sel_seen = wb_sel; imm_seen = imm; wa_seen = wb_addr;
            end
            if (alu_op !== ALU_HOLD) begin
                ex_n++; ex_at = k; op_seen = alu_op;
            end
            @(negedge clk);
        end
        m_pc = npc;
        check("pc_next", 32'(pc), 32'(m_pc));
        check("we_count", 32'(we_n), 32'(op <= 4'h5));
        check("alu_cycles", 32'(ex_n), 32'(op <= 4'h4));
        check("halted_run", 32'(halted), 32'(0));
        if (we_n == 1) begin
            check("we_cycle", 32'(we_at), 32'(cyc - 1));
            check("wb_sel", 32'(sel_seen), 32'(op == 4'h5));
            check("wb_addr", 32'(wa_seen), 32'(rd));
            check("rf_data", 32'(rf[rd]), 32'(m_rf[rd]));
            if (op == 4'h5) check("ldi_imm", 32'(imm_seen), 32'(im));
        end
        if (ex_n == 1) begin
            check("alu_op", 32'(op_seen), 32'(op));
            check("alu_cycle", 32'(ex_at), 32'(2));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'hA000;
        model_reset();

        // reset state, then a reset landing in the EXEC cycle of ADD
        imem[0] = ins(OP_ADD, 2'd0, 2'd0, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_pc", 32'(pc), 32'(0));
        check("rst_alu_op", 32'(alu_op), 32'(4'hF));
        check("rst_reg_we", 32'(reg_we), 32'(0));
        check("rst_wb_sel", 32'(wb_sel), 32'(0));
        check("rst_ra", 32'(ra_addr), 32'(0));
        check("rst_rb", 32'(rb_addr), 32'(0));
        check("rst_wb", 32'(wb_addr), 32'(0));
        check("rst_imm", 32'(imm), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        repeat (2) @(negedge clk);
        check("exec_op", 32'(alu_op), 32'(0));
        do_reset();
        check("exec_rst_pc", 32'(pc), 32'(0));
        check("exec_rst_alu_op", 32'(alu_op), 32'(4'hF));
        check("exec_rst_we", 32'(reg_we), 32'(0));
        @(negedge clk);
        check("exec_rst_we2", 32'(reg_we), 32'(0));
        do_reset();

        // reset landing in the WB cycle of an LDI must not write
        imem[0] = ins(OP_LDI, 2'd2, 2'd0, 8'h5A);
        repeat (2) @(negedge clk);
        check("wb_we", 32'(reg_we), 32'(1));
        rst_n = 1'b0;
        #1 check("wb_we_rst", 32'(reg_we), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("wb_rst_pc", 32'(pc), 32'(0));
        check("wb_rst_we", 32'(reg_we), 32'(0));
        check("wb_rst_rf", 32'(rf[2]), 32'(m_rf[2]));

        // directed program: LDI/ADD, JZ taken and not taken, JC after LDI, pc wrap
        imem[8'h00] = ins(OP_LDI, 2'd1, 2'd0, 8'h05);
        imem[8'h01] = ins(OP_ADD, 2'd1, 2'd1, 8'h00);
        imem[8'h02] = ins(OP_SUB, 2'd2, 2'd2, 8'h00);
        imem[8'h03] = ins(OP_JZ,  2'd0, 2'd0, 8'h40);
        imem[8'h40] = ins(OP_SUB, 2'd1, 2'd2, 8'h00);
        imem[8'h41] = ins(OP_JZ,  2'd0, 2'd0, 8'h10);
        imem[8'h42] = ins(OP_LDI, 2'd3, 2'd0, 8'hF0);
        imem[8'h43] = ins(OP_ADD, 2'd3, 2'd3, 8'h00);
        imem[8'h44] = ins(OP_LDI, 2'd0, 2'd0, 8'h01);
        imem[8'h45] = ins(OP_JC,  2'd0, 2'd0, 8'h80);
        imem[8'h80] = ins(OP_JMP, 2'd0, 2'd0, 8'hFF);
        imem[8'hFF] = 16'hA000;
        repeat (12) step();
        check("wrap_pc", 32'(pc), 32'(8'h00));
        check("r1_value", 32'(rf[1]), 32'(8'h0A));
        check("r3_value", 32'(rf[3]), 32'(8'hE0));
        check("r0_value", 32'(rf[0]), 32'(8'h01));

        // HALT freezes everything until reset
        imem[0] = 16'hF000;
        check("halt_fetch", 32'(halted), 32'(0));
        @(negedge clk);
        check("halt_decode", 32'(halted), 32'(0));
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            check("halt_flag", 32'(halted), 32'(1));
            check("halt_pc", 32'(pc), 32'(0));
            check("halt_alu_op", 32'(alu_op), 32'(4'hF));
            check("halt_we", 32'(reg_we), 32'(0));
            @(negedge clk);
        end
        do_reset();
        check("halt_rst_flag", 32'(halted), 32'(0));
        check("halt_rst_pc", 32'(pc), 32'(0));

        // random programs without HALT
        for (int i = 0; i < 256; i++) imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        do_reset();
        repeat (150) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the single-cycle-processor datapath. It fetches 16-bit instructions, decodes them, drives the ALU opcode and register-file addresses, and writes results back. It also latches the ALU flags and resolves conditional jumps from them. It is the issuing end of the ALU interface: it produces `op` and operand selects, and consumes `result`-timing and the zero/carry/negative flags.

## Interface
- `PC_WIDTH`, default 8: program counter width; wraps modulo 2^PC_WIDTH.
- `clk`  in  1  single system clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr`  in  16  instruction word at address `pc`; valid combinationally while in FETCH.
- `zero_flag`  in  1  ALU zero flag.
- `carrier_flag`  in  1  ALU carry flag.
- `negative_flag`  in  1  ALU negative flag.
- `pc`  out  PC_WIDTH  instruction address.
- `alu_op`  out  4  ALU opcode; 4'hF (ALU_HOLD) outside EXEC.
- `ra_addr`  out  2  register driving ALU `val_a` (= rd).
- `rb_addr`  out  2  register driving ALU `val_b` (= rs).
- `wb_addr`  out  2  register-file write address (= rd).
- `reg_we`  out  1  register-file write enable, one cycle.
- `wb_sel`  out  1  0 = ALU result, 1 = immediate.
- `imm`  out  8  immediate field of current instruction.
- `halted`  out  1  high while in HALT.

## Operation
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- ALU opcodes pass through unchanged: 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 MOV.
- Non-ALU opcodes:
  - 5 LDI: rd ← imm.
  - 6 JMP: pc ← imm.
  - 7 JZ, 8 JC, 9 JN: pc ← imm if the latched Z / C / N flag is set, else pc+1.
  - F HALT.
  - A–E: NOP, pc+1.
- FSM states: FETCH, DECODE, EXEC, WB, HALT.
  - FETCH: latch `instr` into IR → DECODE.
  - DECODE: ALU ops → EXEC; LDI → WB; jumps/NOP update pc → FETCH; HALT → HALT.
  - EXEC: `alu_op` = IR opcode. The ALU registers the result at the end of this cycle → WB.
  - WB: `reg_we`=1, `wb_addr`=rd. For ALU ops, latch the three flags into Z/C/N. pc ← pc+1 → FETCH.
  - HALT: absorbing; only reset leaves it.
- LDI does not modify the flags. Jumps and NOPs do not modify the flags.
- pc increment wraps: 8'hFF + 1 = 8'h00. A jump target is imm truncated/zero-extended to PC_WIDTH.
- `alu_op` is ALU_HOLD in every state except EXEC, so the ALU result and flags are stable in WB and between instructions.

## Timing
- Reset (rst_n low at an edge): state FETCH, pc 0, IR 0, Z/C/N 0. Outputs: `alu_op` 4'hF, `reg_we` 0, `wb_sel` 0, addresses 0, `imm` 0, `halted` 0.
- Reset has priority over all transitions, including mid-EXEC or WB. A write due in WB at the same edge as reset is suppressed.
- Cycles per instruction:
  - ALU op: 4 (FETCH, DECODE, EXEC, WB).
  - LDI: 3.
  - JMP/Jcc/NOP: 2.
- Flag hazard: a Jcc immediately after an ALU op sees that op's flags, because they were latched in WB before the next FETCH.
- `reg_we` is high in exactly one cycle per ALU/LDI instruction and never in other states.
- All outputs are registered state or combinational decode of state+IR. There is no combinational path from `instr` to outputs.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_ADD…OP_HALT);
  - ALU_HOLD = 4'hF;
  - the FSM state enum;
  - instruction field position constants.
  - The ALU uses the same opcode constants.
- One sub-module, `branch_eval`: combinational; takes opcode plus Z/C/N and returns take_branch.
- Everything else is inline: FSM, pc register, IR, flag register.

## Test plan
- Reset mid-EXEC of ADD: assert rst_n=0 for one edge → pc=0, state FETCH, `reg_we` never pulses, `alu_op`=4'hF.
- LDI r1,8'h05, then ADD r1,r1 with r1 held at 5 by a model:
  - LDI: `reg_we` pulse with `wb_sel`=1 and `imm`=5 at cycle 3.
  - ADD: `alu_op`=0 for exactly one cycle, `reg_we` 1 cycle later with `wb_sel`=0.
  - pc=2 afterwards.
- SUB giving zero, then JZ 8'h40:
  - Model drives `zero_flag`=1 in WB → pc=8'h40 two cycles after the JZ fetch.
  - Repeat with `zero_flag`=0 → pc=prev+1.
- JC after an LDI that followed a carrying ADD: the latched C is still 1 (LDI leaves the flags untouched) → branch taken.
- pc wrap: JMP 8'hFF, then a NOP at 8'hFF → next pc=8'h00.
- HALT: `halted`=1 from the cycle after DECODE. pc, `alu_op`=4'hF and `reg_we`=0 stay frozen for 20 cycles. rst_n low → `halted`=0, pc=0.
